// File: rtl/int_pkg.sv
// int_pkg: interrupt-vector sizing and source bit indices shared by int_ctrl
// and its 32 kHz input stage int_src_sync.
package int_pkg;

    localparam int INT_NW    = 11;
    localparam int INT_DEB_W = 4;

    localparam int INT_IDX_RESET       = 0;
    localparam int INT_IDX_FIFO_UPOV   = 1;
    localparam int INT_IDX_FIFO_DOWNOV = 2;
    localparam int INT_IDX_FIFO_WL     = 3;
    localparam int INT_IDX_TIMER       = 4;
    localparam int INT_IDX_USER        = 5;
    localparam int INT_IDX_FRAME_DONE  = 6;
    localparam int INT_IDX_SAMPLE_ERR  = 7;
    localparam int INT_IDX_CAP_CANCEL  = 8;
    localparam int INT_IDX_LDO_OV      = 9;
    localparam int INT_IDX_CIRCUIT_EXC = 10;

endpackage

// File: rtl/int_tgl_rx.sv
// int_tgl_rx: one toggle-handshake receiver into clk_32k. Emits a registered
// one-cycle pulse per received toggle once primed; ack mirrors the consumed toggle.
module int_tgl_rx (
    input  logic clk_32k,
    input  logic rst_n,
    input  logic req_tgl,
    input  logic primed,
    output logic pulse,
    output logic ack_tgl
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic pulse_q, pulse_d;

    // Next-state: three-stage shift, pulse on s2/s3 disagreement once primed.
    always_comb begin
        s1_d    = req_tgl;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pulse_d = (s2_q ^ s3_q) & primed;
    end

    // State registers.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse   = pulse_q;
    assign ack_tgl = s3_q;

endmodule

// File: rtl/int_src_sync.sv
// int_src_sync: brings int_ctrl's foreign-domain inputs into clk_32k.
// Define INT_SRC_SYNC_DEBOUNCE_EN to compile in the analog-flag debouncers.
module int_src_sync
    import int_pkg::*;
#(
    parameter int NW    = INT_NW,
    parameter int DEB_W = INT_DEB_W
) (
    input  logic             clk_32k,
    input  logic             rst_n,
    input  logic [NW-1:0]    clr_req_tgl,
    output logic [NW-1:0]    clr_ack_tgl,
    input  logic             user_req_tgl,
    output logic             user_ack_tgl,
    input  logic             timer_on_a,
    input  logic             frame_on_a,
    input  logic             ldo_ov_a,
    input  logic             circuit_exc_a,
    input  logic [DEB_W-1:0] rg_deb_len,
    output logic [NW-1:0]    int_clr_sync,
    output logic             user_trig_sync,
    output logic             timer_on_sync,
    output logic             frame_on_sync,
    output logic             ldo_ov_flag,
    output logic             circuit_exc_flag
);

    logic [1:0]  prime_cnt_q, prime_cnt_d;
    logic        primed_s;
    logic [NW:0] req_all_s, ack_all_s, pulse_all_s;

    // Prime counter: saturates at 3 so stale toggles across reset are absorbed.
    always_comb begin
        if (prime_cnt_q == 2'd3) begin
            prime_cnt_d = 2'd3;
        end else begin
            prime_cnt_d = prime_cnt_q + 2'd1;
        end
    end

    // Prime counter register.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= 2'd0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
        end
    end

    assign primed_s  = (prime_cnt_q == 2'd3);
    assign req_all_s = {user_req_tgl, clr_req_tgl};

    for (genvar i = 0; i < NW + 1; i++) begin : g_tgl
        int_tgl_rx u_rx (
            .clk_32k (clk_32k),
            .rst_n   (rst_n),
            .req_tgl (req_all_s[i]),
            .primed  (primed_s),
            .pulse   (pulse_all_s[i]),
            .ack_tgl (ack_all_s[i])
        );
    end

    assign int_clr_sync   = pulse_all_s[NW-1:0];
    assign user_trig_sync = pulse_all_s[NW];
    assign clr_ack_tgl    = ack_all_s[NW-1:0];
    assign user_ack_tgl   = ack_all_s[NW];

    // Bit 0: timer_on, bit 1: frame_on, bit 2: ldo_ov, bit 3: circuit_exc.
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

    // Two-flop synchroniser next state for all level inputs.
    always_comb begin
        sync1_d = {circuit_exc_a, ldo_ov_a, frame_on_a, timer_on_a};
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign timer_on_sync = sync2_q[0];
    assign frame_on_sync = sync2_q[1];

`ifdef INT_SRC_SYNC_DEBOUNCE_EN
    logic [1:0][DEB_W-1:0] dcnt_q, dcnt_d;
    logic [1:0]            flt_q, flt_d;

    // True once the count reaches len-1 (or has overshot after a len change).
    function automatic logic deb_hit(input logic [DEB_W-1:0] cnt,
                                     input logic [DEB_W-1:0] len);
        logic [DEB_W:0] nxt;
        nxt = {1'b0, cnt} + {{DEB_W{1'b0}}, 1'b1};
        return (nxt >= {1'b0, len});
    endfunction

    // Debounce next state for ldo_ov (0) and circuit_exc (1).
    always_comb begin
        dcnt_d = dcnt_q;
        flt_d  = flt_q;
        for (int f = 0; f < 2; f++) begin
            if (rg_deb_len == {DEB_W{1'b0}}) begin
                flt_d[f]  = sync2_q[f+2];
                dcnt_d[f] = {DEB_W{1'b0}};
            end else if (sync2_q[f+2] == flt_q[f]) begin
                dcnt_d[f] = {DEB_W{1'b0}};
            end else if (deb_hit(dcnt_q[f], rg_deb_len)) begin
                flt_d[f]  = sync2_q[f+2];
                dcnt_d[f] = {DEB_W{1'b0}};
            end else begin
                dcnt_d[f] = dcnt_q[f] + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            flt_q  <= 2'd0;
        end else begin
            dcnt_q <= dcnt_d;
            flt_q  <= flt_d;
        end
    end

    assign ldo_ov_flag      = flt_q[0];
    assign circuit_exc_flag = flt_q[1];
`else
    logic unused_deb_len_s;
    assign unused_deb_len_s = ^rg_deb_len;

    assign ldo_ov_flag      = sync2_q[2];
    assign circuit_exc_flag = sync2_q[3];
`endif

endmodule

// File: tb/tb_int_src_sync.sv
// tb_int_src_sync: directed self-checking bench for int_src_sync; debounce
// expectations follow INT_SRC_SYNC_DEBOUNCE_EN.
module tb_int_src_sync;

    localparam int NW    = 11;
    localparam int DEB_W = 4;

    logic             clk_32k = 1'b0;
    logic             rst_n;
    logic [NW-1:0]    clr_req_tgl;
    logic [NW-1:0]    clr_ack_tgl;
    logic             user_req_tgl;
    logic             user_ack_tgl;
    logic             timer_on_a;
    logic             frame_on_a;
    logic             ldo_ov_a;
    logic             circuit_exc_a;
    logic [DEB_W-1:0] rg_deb_len;
    logic [NW-1:0]    int_clr_sync;
    logic             user_trig_sync;
    logic             timer_on_sync;
    logic             frame_on_sync;
    logic             ldo_ov_flag;
    logic             circuit_exc_flag;

    int n_checks = 0;
    int n_errors = 0;

    int_src_sync #(.NW(NW), .DEB_W(DEB_W)) dut (
        .clk_32k          (clk_32k),
        .rst_n            (rst_n),
        .clr_req_tgl      (clr_req_tgl),
        .clr_ack_tgl      (clr_ack_tgl),
        .user_req_tgl     (user_req_tgl),
        .user_ack_tgl     (user_ack_tgl),
        .timer_on_a       (timer_on_a),
        .frame_on_a       (frame_on_a),
        .ldo_ov_a         (ldo_ov_a),
        .circuit_exc_a    (circuit_exc_a),
        .rg_deb_len       (rg_deb_len),
        .int_clr_sync     (int_clr_sync),
        .user_trig_sync   (user_trig_sync),
        .timer_on_sync    (timer_on_sync),
        .frame_on_sync    (frame_on_sync),
        .ldo_ov_flag      (ldo_ov_flag),
        .circuit_exc_flag (circuit_exc_flag)
    );

    always #15 clk_32k = ~clk_32k;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_32k);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_req_tgl   = 11'h000;
        user_req_tgl  = 1'b1;
        timer_on_a    = 1'b0;
        frame_on_a    = 1'b0;
        ldo_ov_a      = 1'b0;
        circuit_exc_a = 1'b0;
        rg_deb_len    = 4'd4;

        repeat (3) tick();
        check_eq("rst_clr_ack",   32'(clr_ack_tgl), 32'h0);
        check_eq("rst_user_ack",  32'(user_ack_tgl), 32'h0);
        check_eq("rst_int_clr",   32'(int_clr_sync), 32'h0);
        check_eq("rst_user_trig", 32'(user_trig_sync), 32'h0);
        check_eq("rst_timer",     32'(timer_on_sync), 32'h0);
        check_eq("rst_frame",     32'(frame_on_sync), 32'h0);
        check_eq("rst_ldo",       32'(ldo_ov_flag), 32'h0);
        check_eq("rst_circ",      32'(circuit_exc_flag), 32'h0);

        // user_req_tgl held high through reset must not trigger.
        @(negedge clk_32k);
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check_eq("prime_no_user_trig", 32'(user_trig_sync), 32'h0);
            check_eq("prime_no_clr",       32'(int_clr_sync), 32'h0);
            if (t == 2) check_eq("prime_ack_e2", 32'(user_ack_tgl), 32'h0);
            if (t == 3) check_eq("prime_ack_e3", 32'(user_ack_tgl), 32'h1);
        end

        // Single clear toggle on bit 3.
        clr_req_tgl = 11'h008;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check_eq("clr3_pulse", 32'(int_clr_sync), (t == 3) ? 32'h008 : 32'h0);
            check_eq("clr3_ack",   32'(clr_ack_tgl),  (t >= 3) ? 32'h008 : 32'h0);
            check_eq("clr3_user",  32'(user_trig_sync), 32'h0);
        end

        // Bits 0, 5, 10 and the user trigger toggled together.
        clr_req_tgl  = 11'h429;
        user_req_tgl = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check_eq("multi_pulse", 32'(int_clr_sync),   (t == 3) ? 32'h421 : 32'h0);
            check_eq("multi_user",  32'(user_trig_sync), (t == 3) ? 32'h1 : 32'h0);
        end
        check_eq("multi_ack",      32'(clr_ack_tgl), 32'h429);
        check_eq("multi_user_ack", 32'(user_ack_tgl), 32'h0);

        // Level synchronisers: 2-cycle lag both ways.
        frame_on_a = 1'b1;
        timer_on_a = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            check_eq("frame_sync", 32'(frame_on_sync), (t >= 2 && t < 5) ? 32'h1 : 32'h0);
            check_eq("timer_sync", 32'(timer_on_sync), (t >= 2) ? 32'h1 : 32'h0);
            if (t == 3) frame_on_a = 1'b0;
        end

`ifdef INT_SRC_SYNC_DEBOUNCE_EN
        // 3-cycle glitch with length 4 is suppressed.
        ldo_ov_a = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check_eq("deb_glitch", 32'(ldo_ov_flag), 32'h0);
            if (t == 3) ldo_ov_a = 1'b0;
        end
        // 10-cycle high: rises 6 after rise, falls 6 after fall.
        ldo_ov_a = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check_eq("deb_long", 32'(ldo_ov_flag), (t >= 6 && t < 16) ? 32'h1 : 32'h0);
            if (t == 10) ldo_ov_a = 1'b0;
        end
        // Length 0: follow synced value through the flag register (3 cycles).
        rg_deb_len    = 4'd0;
        tick();
        circuit_exc_a = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check_eq("deb_bypass", 32'(circuit_exc_flag), (t >= 3 && t < 6) ? 32'h1 : 32'h0);
            if (t == 3) circuit_exc_a = 1'b0;
        end
`else
        // No debouncer: flags are plain 2-flop syncs, glitches pass through.
        ldo_ov_a      = 1'b1;
        circuit_exc_a = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check_eq("plain_ldo",  32'(ldo_ov_flag),      (t >= 2 && t < 5) ? 32'h1 : 32'h0);
            check_eq("plain_circ", 32'(circuit_exc_flag), (t >= 2 && t < 5) ? 32'h1 : 32'h0);
            if (t == 3) begin
                ldo_ov_a      = 1'b0;
                circuit_exc_a = 1'b0;
            end
        end
`endif

        // Reset mid-activity clears everything.
        clr_req_tgl = 11'h42B;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rerst_ack",   32'(clr_ack_tgl), 32'h0);
        check_eq("rerst_pulse", 32'(int_clr_sync), 32'h0);
        check_eq("rerst_frame", 32'(frame_on_sync), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
